io_bridge_m: RTL
================

Name: io_bridge_m

Overview:
- Memory-stage responder for I/O accesses.
- Accepts the store byte-enable op (BeOP), load-extend op (MeOP), IOWrite and an I/O-select from the M stage.
- Runs a multi-cycle req/ack transaction on the slow device bus and stalls the pipeline until it completes.
- Returns aligned, extended load data to the W-stage mux, plus a one-cycle valid.

Parameters:
TIMEOUT, 16, max REQ cycles waiting for dev_ack before abort (≥2)
DEV_AW, 30, device word-address width (addr[31:2])

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
io_sel  in  1  current M-stage address decodes to IO space
IOWrite  in  1  store to IO this cycle
BeOP  in  2  store op: `BE_NONE=00, `BE_SB=01, `BE_SH=10, `BE_SW=11 (public.v)
MeOP  in  3  load op: `ME_NONE=000, `ME_LW=001, `ME_LBU=010, `ME_LB=011, `ME_LHU=100, `ME_LH=101 (public.v)
addr  in  32  M-stage byte address
wdata  in  32  M-stage store data (rt value)
stall  out  1  freeze F/D/E/M, bubble W
rdata  out  32  extended load result
rdata_valid  out  1  rdata valid this cycle
addr_err  out  1  one-cycle misalignment/timeout pulse to CP0
dev_req  out  1  device request, held until ack
dev_we  out  1  1=write
dev_addr  out  DEV_AW  word address
dev_be  out  4  byte enables
dev_wdata  out  32  lane-replicated write data
dev_ack  in  1  device completion, single-cycle pulse
dev_rdata  in  32  device read word, valid with dev_ack

Behaviour:
- Reset (reset=0, async): state=IDLE. stall, rdata_valid, addr_err, dev_req, dev_we = 0; dev_addr, dev_be, dev_wdata, rdata = 0. A reset mid-transaction drops dev_req immediately. Any late dev_ack is ignored.
- start = IOWrite | (io_sel & MeOP!=`ME_NONE). It is only evaluated in IDLE.
- stall = (IDLE & start & !misaligned) | (state==REQ). This is combinational so the M instruction freezes in its start cycle.
- Misaligned: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0.
  - At start: no device access, addr_err=1 for one cycle, stay IDLE.
- IDLE, valid start: on the clock edge, latch the following and go to REQ with dev_req=1:
  - dev_addr=addr[31:2]
  - dev_we=IOWrite
  - off=addr[1:0]
  - op=MeOP
  - dev_be: SB: 1<<off. SH: off[1]?1100:0011. SW, and all loads: 1111.
  - dev_wdata: SB: {4{wdata[7:0]}}. SH: {2{wdata[15:0]}}. SW: wdata.
- REQ: dev_req held at 1, with dev_addr/dev_be/dev_wdata/dev_we stable.
  - On dev_ack: dev_req=0; for reads, register the extended result into rdata; go to DONE.
  - Counter counts REQ cycles. If it reaches TIMEOUT without ack: dev_req=0, rdata=0, addr_err pulse, go to DONE.
- DONE (one cycle): stall=0, rdata_valid=1. start is ignored, because the same instruction is still in M. Next state is IDLE.
- Load extension uses latched op/off on dev_rdata:
  - LB/LBU: byte off, sign- or zero-extended.
  - LH/LHU: halfword off[1], sign- or zero-extended.
  - LW: full word.
- Back-to-back IO accesses: minimum 3 cycles each (IDLE, REQ, DONE) with a 1-cycle ack. No overlap.
- dev_ack outside REQ is ignored.
- Stores also pass through DONE; rdata_valid=1 there but rdata holds 0.

Test Plan:
- SB, addr=0x7F10_0002, wdata=0x0000_00A5, ack after 3 cycles:
  - dev_be=0100, dev_wdata=0xA5A5A5A5, dev_we=1.
  - stall high 4 cycles, then DONE with stall=0.
- LB, off=3, dev_rdata=0x80_00_00_00 → rdata=0xFFFF_FF80. Same with LBU → 0x0000_0080. rdata_valid one cycle.
- LH, off=2, dev_rdata=0x8001_1234 → rdata=0xFFFF_8001. LHU, off=0 → 0x0000_1234.
- SW to addr=0x…0002 → addr_err one cycle, dev_req never rises, stall stays 0.
- Read with dev_ack withheld → after TIMEOUT=16 REQ cycles: dev_req=0, addr_err=1, rdata=0, stall releases in DONE.
- reset=0 asserted mid-REQ → all outputs 0 the same cycle. A dev_ack pulse after release is ignored; state=IDLE.

Source files
------------

// File: rtl/io_bridge_m.sv
// M-stage I/O responder: one device req/ack transaction per access; IDLE->REQ->DONE, 3 cycles minimum with a 1-cycle ack.
// Backpressure: stall holds F/D/E/M from the start cycle until DONE; REQ aborts after TIMEOUT cycles without dev_ack.
module io_bridge_m #(
   parameter int TIMEOUT = 16,
   parameter int DEV_AW  = 30
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_sel,
   input  logic              IOWrite,
   input  logic [1:0]        BeOP,
   input  logic [2:0]        MeOP,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
   output logic              addr_err,
   output logic              dev_req,
   output logic              dev_we,
   output logic [DEV_AW-1:0] dev_addr,
   output logic [3:0]        dev_be,
   output logic [31:0]       dev_wdata,
   input  logic              dev_ack,
   input  logic [31:0]       dev_rdata
);

   localparam logic [1:0] BE_SB = 2'b01, BE_SH = 2'b10, BE_SW = 2'b11;
   localparam logic [2:0] ME_NONE = 3'b000, ME_LW = 3'b001, ME_LBU = 3'b010,
                          ME_LB = 3'b011, ME_LHU = 3'b100, ME_LH = 3'b101;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic [2:0]    op;
   logic [1:0]    off;
   logic          err_q;
   logic          start, misaligned, go, cnt_last;
   logic [3:0]    be_c;
   logic [31:0]   wd_c, ext;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;

   assign start    = IOWrite | (io_sel & (MeOP != ME_NONE));
   assign go       = start & ~misaligned;
   assign cnt_last = (cnt == CNT_LAST);

   // Alignment is judged against the op that actually applies: BeOP for stores, MeOP for loads.
   always_comb begin
      misaligned = 1'b0;
      if (IOWrite)
         misaligned = ((BeOP == BE_SH) && addr[0]) || ((BeOP == BE_SW) && (addr[1:0] != 2'b00));
      else
         misaligned = (((MeOP == ME_LH) || (MeOP == ME_LHU)) && addr[0]) ||
                      ((MeOP == ME_LW) && (addr[1:0] != 2'b00));
   end

   always_comb begin
      be_c = 4'b1111;
      wd_c = wdata;
      if (IOWrite) begin
         case (BeOP)
            BE_SB:   begin be_c = 4'b0001 << addr[1:0]; wd_c = {4{wdata[7:0]}}; end
            BE_SH:   begin be_c = addr[1] ? 4'b1100 : 4'b0011; wd_c = {2{wdata[15:0]}}; end
            BE_SW:   be_c = 4'b1111;
            default: be_c = 4'b0000;
         endcase
      end
   end

   always_comb begin
      case (off)
         2'd0:    byte_sel = dev_rdata[7:0];
         2'd1:    byte_sel = dev_rdata[15:8];
         2'd2:    byte_sel = dev_rdata[23:16];
         default: byte_sel = dev_rdata[31:24];
      endcase
      half_sel = off[1] ? dev_rdata[31:16] : dev_rdata[15:0];
      case (op)
         ME_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
         ME_LBU:  ext = {24'd0, byte_sel};
         ME_LH:   ext = {{16{half_sel[15]}}, half_sel};
         ME_LHU:  ext = {16'd0, half_sel};
         default: ext = dev_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Outputs are gated by reset so nothing combinational leaks out while the block is held in reset.
   always_comb begin
      next_state  = state;
      stall       = 1'b0;
      addr_err    = 1'b0;
      rdata_valid = 1'b0;
      dev_req     = 1'b0;
      case (state)
         IDLE: begin
            stall    = reset & go;
            addr_err = reset & start & misaligned;
            if (go) next_state = REQ;
         end
         REQ: begin
            stall   = 1'b1;
            dev_req = 1'b1;
            if (dev_ack || cnt_last) next_state = DONE;
         end
         DONE: begin
            rdata_valid = 1'b1;
            addr_err    = err_q;
            next_state  = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dev_we    <= 1'b0;
         dev_addr  <= '0;
         dev_be    <= '0;
         dev_wdata <= '0;
         rdata     <= '0;
         op        <= '0;
         off       <= '0;
         cnt       <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: if (go) begin
               dev_we    <= IOWrite;
               dev_addr  <= addr[DEV_AW+1:2];
               dev_be    <= be_c;
               dev_wdata <= wd_c;
               op        <= MeOP;
               off       <= addr[1:0];
               rdata     <= '0;
               cnt       <= '0;
            end
            REQ: begin
               if (dev_ack) begin
                  if (!dev_we) rdata <= ext;
               end else if (cnt_last) begin
                  rdata <= '0;
                  err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
